crtg_engine_ctrl: RTL and testbench

- Synthesizable controller for coverage-driven random test generation (CRTG) with fault dropping. Successor to the software fault-simulation loop.
- Generates pseudo-random scan vectors with a parametrised LFSR and walks the collapsed fault list, issuing only undropped faults to an external good/faulty simulation engine.
- Keeps a vector only if it detects at least EF_COUNT new faults, and streams kept vectors plus the good-machine response out through a valid/ready port.
- Stops when the coverage target or the useless-test limit is reached.

---
 rtl/crtg_engine_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_crtg_engine_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/crtg_engine_ctrl.sv
// CRTG controller: LFSR vectors, walks undropped faults through an external engine, keeps vectors with >= EF_COUNT new detects.
// Two cycles from start to first flt_req; one skip cycle per dropped fault; kv_ready low stalls in EMIT with no fault requests.
module crtg_engine_ctrl #(
    parameter int VEC_W      = 32,
    parameter int RESP_W     = 32,
    parameter int NUM_FAULTS = 1317,
    parameter int FIDX_W     = 11,
    parameter int EF_COUNT   = 2,
    parameter int UT_LIMIT   = 300,
    parameter int COV_PCT    = 90,
    parameter logic [VEC_W-1:0] LFSR_POLY = 32'h80200003,
    parameter logic [VEC_W-1:0] LFSR_SEED = 32'h1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                done_reason,
    output logic [VEC_W-1:0]          vec,
    output logic                      flt_req,
    output logic [FIDX_W-1:0]         flt_idx,
    input  logic                      flt_ack,
    input  logic                      flt_det,
    input  logic [RESP_W-1:0]         good_resp,
    output logic                      kv_valid,
    input  logic                      kv_ready,
    output logic [VEC_W+RESP_W-1:0]   kv_data,
    output logic [FIDX_W:0]           det_total,
    output logic [15:0]               kept_cnt,
    output logic [15:0]               total_cnt
);

    localparam int                IW      = FIDX_W + 1;
    localparam logic [VEC_W-1:0]  LP_SEED = (LFSR_SEED == '0) ? '1 : LFSR_SEED;
    localparam logic [IW-1:0]     LP_NF   = IW'(NUM_FAULTS);
    localparam logic [IW-1:0]     LP_EF   = IW'(EF_COUNT);
    localparam logic [15:0]       LP_UT   = 16'(UT_LIMIT);
    localparam logic [47:0]       LP_COV  = 48'(COV_PCT) * 48'(NUM_FAULTS);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_SCAN, S_WAIT, S_EVAL, S_EMIT, S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [VEC_W-1:0]           r_lfsr;
    logic [VEC_W-1:0]           r_vec;
    logic [NUM_FAULTS-1:0]      r_at;
    logic [NUM_FAULTS-1:0]      r_ct;
    logic [IW-1:0]              r_idx;
    logic [IW-1:0]              r_ndet;
    logic [IW-1:0]              r_det_total;
    logic [15:0]                r_kept;
    logic [15:0]                r_total;
    logic [15:0]                r_ut;
    logic [1:0]                 r_reason;
    logic [VEC_W+RESP_W-1:0]    r_kv_data;

    logic [VEC_W-1:0]           w_lfsr_nxt;
    logic [FIDX_W-1:0]          w_fidx;
    logic                       w_idx_end;
    logic                       w_dropped;
    logic                       w_keep;
    logic [15:0]                w_ut_inc;
    logic                       w_cov_hit;
    logic                       w_flt_req;

    // Right-shifting Galois LFSR: the shifted-out bit gates the tap mask.
    assign w_lfsr_nxt = {1'b0, r_lfsr[VEC_W-1:1]} ^ (r_lfsr[0] ? LFSR_POLY : '0);
    assign w_fidx     = r_idx[FIDX_W-1:0];
    assign w_idx_end  = (r_idx == LP_NF);
    assign w_dropped  = r_at[w_fidx];
    assign w_keep     = (r_ndet >= LP_EF);
    assign w_ut_inc   = r_ut + 16'd1;
    assign w_cov_hit  = (48'(r_det_total) * 48'd100) >= LP_COV;

    always_comb begin
        w_next    = r_state;
        w_flt_req = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = (COV_PCT == 0) ? S_DONE : S_GEN;
            S_GEN:  w_next = S_SCAN;
            S_SCAN: begin
                if (w_idx_end) begin
                    w_next = S_EVAL;
                end else if (!w_dropped) begin
                    w_flt_req = 1'b1;
                    w_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                w_flt_req = 1'b1;
                if (flt_ack) w_next = S_SCAN;
            end
            S_EVAL: begin
                if (w_keep)                 w_next = S_EMIT;
                else if (w_ut_inc == LP_UT) w_next = S_DONE;
                else                        w_next = S_GEN;
            end
            S_EMIT: if (kv_ready) w_next = w_cov_hit ? S_DONE : S_GEN;
            S_DONE: if (start) w_next = S_GEN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lfsr      <= LP_SEED;
            r_vec       <= '0;
            r_at        <= '0;
            r_ct        <= '0;
            r_idx       <= '0;
            r_ndet      <= '0;
            r_det_total <= '0;
            r_kept      <= '0;
            r_total     <= '0;
            r_ut        <= '0;
            r_reason    <= '0;
            r_kv_data   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start && COV_PCT == 0) r_reason <= 2'b01;
                S_GEN: begin
                    r_lfsr <= w_lfsr_nxt;
                    r_vec  <= w_lfsr_nxt;
                    r_ct   <= '0;
                    r_ndet <= '0;
                    r_idx  <= '0;
                    if (r_total != 16'hFFFF) r_total <= r_total + 16'd1;
                end
                S_SCAN: if (!w_idx_end && w_dropped) r_idx <= r_idx + IW'(1);
                S_WAIT: begin
                    if (flt_ack) begin
                        if (flt_det) begin
                            r_ct[w_fidx] <= 1'b1;
                            r_ndet       <= r_ndet + IW'(1);
                        end
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_EVAL: begin
                    if (w_keep) begin
                        r_at        <= r_at | r_ct;
                        r_det_total <= r_det_total + r_ndet;
                        r_kept      <= r_kept + 16'd1;
                        r_ut        <= '0;
                        r_kv_data   <= {r_vec, good_resp};
                    end else begin
                        r_ut <= w_ut_inc;
                        if (w_ut_inc == LP_UT) r_reason <= 2'b10;
                    end
                end
                S_EMIT: if (kv_ready && w_cov_hit) r_reason <= 2'b01;
                S_DONE: begin
                    // Restart keeps the LFSR running so the new run explores fresh vectors.
                    if (start) begin
                        r_at        <= '0;
                        r_det_total <= '0;
                        r_kept      <= '0;
                        r_total     <= '0;
                        r_ut        <= '0;
                        r_reason    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done        = (r_state == S_DONE);
    assign done_reason = r_reason;
    assign vec         = r_vec;
    assign flt_req     = w_flt_req;
    assign flt_idx     = w_fidx;
    assign kv_valid    = (r_state == S_EMIT);
    assign kv_data     = r_kv_data;
    assign det_total   = r_det_total;
    assign kept_cnt    = r_kept;
    assign total_cnt   = r_total;

endmodule

// File: tb/tb_crtg_engine_ctrl.sv
// Directed bench for crtg_engine_ctrl with 8 faults, EF 2, useless limit 3, 75% target.
module tb_crtg_engine_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  done_reason;
    logic [31:0] vec;
    logic        flt_req;
    logic [2:0]  flt_idx;
    logic        flt_ack;
    logic        flt_det;
    logic [31:0] good_resp;
    logic        kv_valid;
    logic        kv_ready;
    logic [63:0] kv_data;
    logic [3:0]  det_total;
    logic [15:0] kept_cnt;
    logic [15:0] total_cnt;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] seen;
    bit         ok;

    crtg_engine_ctrl #(
        .VEC_W(32), .RESP_W(32), .NUM_FAULTS(8), .FIDX_W(3),
        .EF_COUNT(2), .UT_LIMIT(3), .COV_PCT(75),
        .LFSR_POLY(32'h80200003), .LFSR_SEED(32'h1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .done_reason(done_reason), .vec(vec), .flt_req(flt_req), .flt_idx(flt_idx),
        .flt_ack(flt_ack), .flt_det(flt_det), .good_resp(good_resp),
        .kv_valid(kv_valid), .kv_ready(kv_ready), .kv_data(kv_data),
        .det_total(det_total), .kept_cnt(kept_cnt), .total_cnt(total_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine answers each request one cycle later (in WAIT) with det from mask.
    task automatic run_vec(input logic [7:0] mask, output logic [7:0] req_seen, output bit fin);
        logic [15:0] t0;
        t0       = total_cnt;
        req_seen = '0;
        fin      = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (kv_valid || done || total_cnt != t0) begin
                fin = 1'b1;
                break;
            end
            if (flt_req) begin
                req_seen[flt_idx] = 1'b1;
                step();
                flt_ack = 1'b1;
                flt_det = mask[flt_idx];
                step();
                flt_ack = 1'b0;
                flt_det = 1'b0;
            end else begin
                step();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flt_ack = 1'b0; flt_det = 1'b0;
        kv_ready = 1'b0; good_resp = 32'hA5A5_0001;
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_reason", 64'(done_reason), 64'd0);
        check("rst_vec", 64'(vec), 64'd0);
        check("rst_req", 64'(flt_req), 64'd0);
        check("rst_kv", {63'd0, kv_valid}, 64'd0);
        check("rst_kvdata", kv_data, 64'd0);
        check("rst_cnts", {16'(det_total), kept_cnt, total_cnt}, 48'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("idle_busy", 64'(busy), 64'd0);

        // Run 1, vector 1: every fault requested, 0..2 detected.
        start = 1'b1; step(); start = 1'b0;
        check("gen_busy", 64'(busy), 64'd1);
        check("gen_req", 64'(flt_req), 64'd0);
        step();
        check("v1_vec", 64'(vec), 64'h80200003);
        check("v1_req", 64'(flt_req), 64'd1);
        check("v1_idx", 64'(flt_idx), 64'd0);
        check("v1_total", 64'(total_cnt), 64'd1);
        run_vec(8'h07, seen, ok);
        check("v1_fin", 64'(ok), 64'd1);
        check("v1_seen", 64'(seen), 64'hFF);
        check("v1_kv", 64'(kv_valid), 64'd1);
        check("v1_kvdata", kv_data, {32'h80200003, 32'hA5A50001});
        check("v1_det", 64'(det_total), 64'd3);
        check("v1_kept", 64'(kept_cnt), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_kv", 64'(kv_valid), 64'd1);
            check("bp_kvdata", kv_data, {32'h80200003, 32'hA5A50001});
            check("bp_req", 64'(flt_req), 64'd0);
        end
        kv_ready = 1'b1; step(); kv_ready = 1'b0;
        check("hs_gen_kv", 64'(kv_valid), 64'd0);
        check("hs_gen_busy", 64'(busy), 64'd1);
        check("hs_gen_total", 64'(total_cnt), 64'd1);

        // Vector 2: idx 0..2 dropped, three skip cycles then idx 3.
        step();
        check("v2_vec", 64'(vec), 64'hC0300002);
        check("v2_total", 64'(total_cnt), 64'd2);
        check("v2_skip0", 64'(flt_req), 64'd0);
        step();
        check("v2_skip1", 64'(flt_req), 64'd0);
        step();
        check("v2_skip2", 64'(flt_req), 64'd0);
        step();
        check("v2_req3", 64'(flt_req), 64'd1);
        check("v2_idx3", 64'(flt_idx), 64'd3);
        run_vec(8'h18, seen, ok);
        check("v2_fin", 64'(ok), 64'd1);
        check("v2_seen", 64'(seen), 64'hF8);
        check("v2_kv", 64'(kv_valid), 64'd1);
        check("v2_det", 64'(det_total), 64'd5);
        check("v2_kept", 64'(kept_cnt), 64'd2);
        check("v2_kvdata", kv_data, {32'hC0300002, 32'hA5A50001});
        kv_ready = 1'b1; step(); kv_ready = 1'b0;
        check("det5_not_done", 64'(done), 64'd0);
        check("det5_busy", 64'(busy), 64'd1);
        step();
        check("v3_vec", 64'(vec), 64'h60180001);

        // Vectors 3..5: one detection each, discarded until the useless limit.
        run_vec(8'h20, seen, ok);
        check("v3_fin", 64'(ok), 64'd1);
        check("v3_seen", 64'(seen), 64'hE0);
        check("v3_kv", 64'(kv_valid), 64'd0);
        check("v4_total", 64'(total_cnt), 64'd4);
        check("v4_vec", 64'(vec), 64'hB02C0003);
        run_vec(8'h20, seen, ok);
        check("v4_fin", 64'(ok), 64'd1);
        check("v4_kv", 64'(kv_valid), 64'd0);
        run_vec(8'h20, seen, ok);
        check("v5_fin", 64'(ok), 64'd1);
        check("ut_done", 64'(done), 64'd1);
        check("ut_reason", 64'(done_reason), 64'd2);
        check("ut_busy", 64'(busy), 64'd0);
        check("ut_total", 64'(total_cnt), 64'd5);
        check("ut_kept", 64'(kept_cnt), 64'd2);
        check("ut_det", 64'(det_total), 64'd5);
        check("ut_kv", 64'(kv_valid), 64'd0);

        // Run 2 from DONE: counters cleared, LFSR continues, six detections reach coverage.
        good_resp = 32'h1234_5678;
        start = 1'b1; step(); start = 1'b0;
        check("r2_done", 64'(done), 64'd0);
        check("r2_reason", 64'(done_reason), 64'd0);
        check("r2_busy", 64'(busy), 64'd1);
        check("r2_cnts", {16'(det_total), kept_cnt}, 32'd0);
        step();
        check("v6_vec", 64'(vec), 64'h6C1B0001);
        check("v6_total", 64'(total_cnt), 64'd1);
        check("v6_req", {flt_req, flt_idx}, {1'b1, 3'd0});
        run_vec(8'h3F, seen, ok);
        check("v6_fin", 64'(ok), 64'd1);
        check("v6_seen", 64'(seen), 64'hFF);
        check("v6_kv", 64'(kv_valid), 64'd1);
        check("v6_det", 64'(det_total), 64'd6);
        check("v6_kvdata", kv_data, {32'h6C1B0001, 32'h12345678});
        check("v6_not_done", 64'(done), 64'd0);
        kv_ready = 1'b1; step(); kv_ready = 1'b0;
        check("cov_done", 64'(done), 64'd1);
        check("cov_reason", 64'(done_reason), 64'd1);
        check("cov_busy", 64'(busy), 64'd0);
        check("cov_kv", 64'(kv_valid), 64'd0);

        // Asynchronous reset while WAIT holds a request, then restart from seed.
        start = 1'b1; step(); start = 1'b0;
        step();
        check("v7_vec", 64'(vec), 64'hB62D8003);
        step();
        check("wait_req", 64'(flt_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", 64'(flt_req), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_det", 64'(det_total), 64'd0);
        check("arst_vec", 64'(vec), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        start = 1'b1; step(); start = 1'b0;
        step();
        check("rs_vec", 64'(vec), 64'h80200003);
        check("rs_req", {flt_req, flt_idx}, {1'b1, 3'd0});
        check("rs_total", 64'(total_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
